// File: rtl/ptw_arbiter.sv
// Shares one combinational page-table walker between the instruction and data sides.
// Latency: the response pulse is sampled WALK_CYCLES+1 edges after the grant edge; at least one IDLE cycle separates walks.
// Backpressure: requesters hold req/vaddr until their pulse; the loser of arbitration waits in IDLE; flush_i aborts a walk silently.
//
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   flush_i                      - abort any in-flight walk, block a grant in IDLE
//   i_req_i/i_vaddr_i            - instruction-side request
//   d_req_i/d_vaddr_i            - data-side request
//   i_valid_o/i_error_o          - instruction-side one-cycle response pulses
//   d_valid_o/d_error_o          - data-side one-cycle response pulses
//   paddr_o                      - translated address, nonzero only with a valid pulse
//   busy_o                       - high whenever the FSM is not IDLE
//   ptw_req_o/ptw_vaddr_o        - walker request (WALK state only)
//   ptw_valid_i/ptw_error_i/ptw_paddr_i - walker result, sampled on the last WALK cycle
// Build option: define PTW_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the data side has fixed priority.
module ptw_arbiter #(
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 20,
  parameter int WALK_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   i_req_i,
  input  logic [VADDR_WIDTH-1:0] i_vaddr_i,
  input  logic                   d_req_i,
  input  logic [VADDR_WIDTH-1:0] d_vaddr_i,
  output logic                   i_valid_o,
  output logic                   i_error_o,
  output logic                   d_valid_o,
  output logic                   d_error_o,
  output logic [PADDR_WIDTH-1:0] paddr_o,
  output logic                   busy_o,
  output logic                   ptw_req_o,
  output logic [VADDR_WIDTH-1:0] ptw_vaddr_o,
  input  logic                   ptw_valid_i,
  input  logic                   ptw_error_i,
  input  logic [PADDR_WIDTH-1:0] ptw_paddr_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, RESP = 2'd2} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WALK_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [VADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic                   res_ok_q, res_ok_d;
  logic [PADDR_WIDTH-1:0] res_paddr_q, res_paddr_d;
  logic                   gnt_data_q, gnt_data_d;  // 1: walk belongs to data side

  logic grant;
  logic grant_data;

  assign grant = (state_q == IDLE) && !flush_i && (i_req_i || d_req_i);

`ifdef PTW_ARB_ROUND_ROBIN_EN
  // Side granted most recently; resets to instruction so the first tie goes to data.
  logic last_data_q, last_data_d;

  assign grant_data  = d_req_i && (!i_req_i || !last_data_q);
  assign last_data_d = grant ? grant_data : last_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_data_q <= 1'b0;
    else         last_data_q <= last_data_d;
  end
`else
  assign grant_data = d_req_i;
`endif

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      vaddr_q     <= '0;
      res_ok_q    <= 1'b0;
      res_paddr_q <= '0;
      gnt_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vaddr_q     <= vaddr_d;
      res_ok_q    <= res_ok_d;
      res_paddr_q <= res_paddr_d;
      gnt_data_q  <= gnt_data_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vaddr_d     = vaddr_q;
    res_ok_d    = res_ok_q;
    res_paddr_d = res_paddr_q;
    gnt_data_d  = gnt_data_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = WALK;
          cnt_d      = 4'd0;
          gnt_data_d = grant_data;
          vaddr_d    = grant_data ? d_vaddr_i : i_vaddr_i;
        end
      end
      WALK: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          // Saturate rather than wrap
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_d     = RESP;
            // Only "valid and not error" is a success; both-low and both-high are errors
            res_ok_d    = ptw_valid_i && !ptw_error_i;
            res_paddr_d = ptw_paddr_i;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; flush masks the RESP pulse in the same cycle
  always_comb begin
    i_valid_o   = 1'b0;
    i_error_o   = 1'b0;
    d_valid_o   = 1'b0;
    d_error_o   = 1'b0;
    paddr_o     = '0;
    busy_o      = 1'b0;
    ptw_req_o   = 1'b0;
    ptw_vaddr_o = '0;
    case (state_q)
      WALK: begin
        busy_o      = 1'b1;
        ptw_req_o   = 1'b1;
        ptw_vaddr_o = vaddr_q;
      end
      RESP: begin
        busy_o = 1'b1;
        if (!flush_i) begin
          i_valid_o = !gnt_data_q &&  res_ok_q;
          i_error_o = !gnt_data_q && !res_ok_q;
          d_valid_o =  gnt_data_q &&  res_ok_q;
          d_error_o =  gnt_data_q && !res_ok_q;
          paddr_o   = res_ok_q ? res_paddr_q : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed self-checking bench for ptw_arbiter (WALK_CYCLES = 4).
module tb_ptw_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        i_req_i, d_req_i;
  logic [31:0] i_vaddr_i, d_vaddr_i;
  logic        i_valid_o, i_error_o, d_valid_o, d_error_o;
  logic [19:0] paddr_o;
  logic        busy_o, ptw_req_o;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_valid_i, ptw_error_i;
  logic [19:0] ptw_paddr_i;

  int checks = 0;
  int failures = 0;

  ptw_arbiter #(.VADDR_WIDTH(32), .PADDR_WIDTH(20), .WALK_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .i_req_i(i_req_i), .i_vaddr_i(i_vaddr_i),
    .d_req_i(d_req_i), .d_vaddr_i(d_vaddr_i),
    .i_valid_o(i_valid_o), .i_error_o(i_error_o),
    .d_valid_o(d_valid_o), .d_error_o(d_error_o),
    .paddr_o(paddr_o), .busy_o(busy_o),
    .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_valid_i(ptw_valid_i), .ptw_error_i(ptw_error_i), .ptw_paddr_i(ptw_paddr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {i_valid_o, i_error_o, d_valid_o, d_error_o};
  endfunction

  // Error-path vectors: side (1 = data), walker valid/error, walker paddr
  logic        tv_side  [3] = '{1'b1, 1'b0, 1'b0};
  logic        tv_valid [3] = '{1'b0, 1'b1, 1'b0};
  logic        tv_error [3] = '{1'b1, 1'b1, 1'b0};
  logic [19:0] tv_paddr [3] = '{20'h0ABCD, 20'h55555, 20'h0F0F0};

  logic exp_d;
  int   cnt;

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    i_req_i = 1'b0; d_req_i = 1'b0; i_vaddr_i = '0; d_vaddr_i = '0;
    ptw_valid_i = 1'b0; ptw_error_i = 1'b0; ptw_paddr_i = '0;

    // Reset state
    #12;
    check("rst_pulses", {28'd0, pulses()}, 32'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ptw_req", ptw_req_o, 1'b0);
    check("rst_paddr", paddr_o, 20'h0);
    check("rst_ptw_vaddr", ptw_vaddr_o, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(negedge clk_i);

    // Single instruction walk with a valid result
    i_req_i = 1'b1; i_vaddr_i = 32'h0000_1000;
    ptw_valid_i = 1'b1; ptw_error_i = 1'b0; ptw_paddr_i = 20'h12345;
    @(posedge clk_i);  // grant edge
    @(negedge clk_i);
    check("walk_busy", busy_o, 1'b1);
    check("walk_ptw_req", ptw_req_o, 1'b1);
    check("walk_vaddr", ptw_vaddr_o, 32'h0000_1000);
    i_vaddr_i = 32'hDEAD_0000;  // must be ignored after grant
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (k == 1) check("vaddr_held", ptw_vaddr_o, 32'h0000_1000);
      check($sformatf("i_valid_c%0d", k), i_valid_o, (k == 4) ? 1'b1 : 1'b0);
      if (k == 4) begin
        check("i_paddr", paddr_o, 20'h12345);
        check("i_err_low", i_error_o, 1'b0);
        check("d_quiet", {d_valid_o, d_error_o}, 2'b00);
        check("resp_ptw_req", ptw_req_o, 1'b0);
        i_req_i = 1'b0;
      end
      if (k == 5) check("idle_after_resp", busy_o, 1'b0);
    end

    // Error results: error alone, valid+error, neither
    for (int t = 0; t < 3; t++) begin
      if (tv_side[t]) begin d_req_i = 1'b1; d_vaddr_i = 32'h2000 + t; end
      else            begin i_req_i = 1'b1; i_vaddr_i = 32'h2000 + t; end
      ptw_valid_i = tv_valid[t]; ptw_error_i = tv_error[t]; ptw_paddr_i = tv_paddr[t];
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      if (tv_side[t])
        check($sformatf("err_pulses_t%0d", t), {28'd0, pulses()}, 32'b0001);
      else
        check($sformatf("err_pulses_t%0d", t), {28'd0, pulses()}, 32'b0100);
      check($sformatf("err_paddr_t%0d", t), paddr_o, 20'h0);
      i_req_i = 1'b0; d_req_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Both sides requesting continuously for four walks (last grant so far: instruction)
    i_req_i = 1'b1; d_req_i = 1'b1; i_vaddr_i = 32'h0011_1000; d_vaddr_i = 32'h0022_2000;
    ptw_valid_i = 1'b1; ptw_error_i = 1'b0; ptw_paddr_i = 20'h00777;
    for (int w = 0; w < 4; w++) begin
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
`ifdef PTW_ARB_ROUND_ROBIN_EN
      exp_d = (w % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("arb_d_w%0d", w), d_valid_o, exp_d);
      check($sformatf("arb_i_w%0d", w), i_valid_o, !exp_d);
      if (w == 3) begin i_req_i = 1'b0; d_req_i = 1'b0; end
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Flush in the second WALK cycle, then re-grant of the held request
    i_req_i = 1'b1; i_vaddr_i = 32'h3000; ptw_paddr_i = 20'h00333;
    @(posedge clk_i); @(negedge clk_i);
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", busy_o, 1'b0);
    check("flush_pulses", {28'd0, pulses()}, 32'd0);
    @(posedge clk_i); @(negedge clk_i);
    check("regrant_busy", busy_o, 1'b1);
    check("regrant_ptw_req", ptw_req_o, 1'b1);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("regrant_valid", i_valid_o, 1'b1);
    check("regrant_paddr", paddr_o, 20'h00333);
    i_req_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);

    // Flush in IDLE blocks the grant; flush in RESP suppresses the pulse
    d_req_i = 1'b1; d_vaddr_i = 32'h4000; flush_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("idle_flush_block", busy_o, 1'b0);
    flush_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    check("post_flush_grant", busy_o, 1'b1);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("resp_before_flush", d_valid_o, 1'b1);
    flush_i = 1'b1; d_req_i = 1'b0;
    #1;
    check("resp_flush_pulse", {28'd0, pulses()}, 32'd0);
    check("resp_flush_paddr", paddr_o, 20'h0);
    @(posedge clk_i); @(negedge clk_i);
    check("resp_flush_idle", busy_o, 1'b0);
    flush_i = 1'b0;

    // Asynchronous reset in the middle of a walk
    i_req_i = 1'b1; i_vaddr_i = 32'h5000;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    check("pre_rst_busy", busy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_ptw_req", ptw_req_o, 1'b0);
    check("arst_ptw_vaddr", ptw_vaddr_o, 32'h0);
    check("arst_pulses", {28'd0, pulses()}, 32'd0);
    i_req_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk_i);
      cnt += (pulses() != 4'd0) ? 1 : 0;
      cnt += busy_o ? 1 : 0;
    end
    check("arst_no_resp", cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
